cycle_count_display: RTL and testbench
======================================

CYCLE_COUNT_DISPLAY -- requirements
Module: cycle_count_display

Interface
REQ-001 SHALL have parameter CNT_W, default 36: elapsed-counter width in bits.
REQ-002 SHALL have parameter DIGITS, default 11: number of BCD digits converted.
REQ-003 SHALL have parameter PAGE_DIGITS, default 3: digits shown per display page.
REQ-004 SHALL have parameter TICK_DIV, default 25000000: clocks per page dwell, at least 1.
REQ-005 SHALL derive NPAGES = ceil(DIGITS/PAGE_DIGITS) and PG_W = max(1, ceil(log2 NPAGES)).
REQ-006 SHALL have port CLOCK_50, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port toggle_btn, input, 1 bit: asynchronous pushbutton, low while pressed.
REQ-009 SHALL have port clr, input, 1 bit: synchronous counter clear.
REQ-010 SHALL have port digits, output, 4*PAGE_DIGITS bits: current page, most-significant digit in the top nibble.
REQ-011 SHALL have port page_idx, output, PG_W bits: index of the displayed page; 0 is the least-significant page.
REQ-012 SHALL have port page_valid, output, 1 bit: digits holds a converted page.
REQ-013 SHALL have port running, output, 1 bit: the counter is counting.
REQ-014 SHALL have port busy, output, 1 bit: a BCD conversion is in progress.

Function
REQ-015 SHALL synchronise toggle_btn through two flops, then detect a falling edge on the synchronised signal (1 to 0) as a single one-cycle toggle pulse.
REQ-016 SHALL invert running on the cycle after each toggle pulse.
REQ-017 SHALL hold counter count (CNT_W bits): clr sets it to 0; otherwise, when running=1 it increments by 1 per clock, wrapping from 2^CNT_W-1 to 0; clr has priority over increment.
REQ-018 SHALL use a state machine with states IDLE, CONV and SHOW.
REQ-019 SHALL in IDLE drive digits to all 4'hF (blank), page_valid=0, page_idx=0 and busy=0.
REQ-020 SHALL, on a running 1->0 transition, snapshot count and enter CONV.
REQ-021 SHALL in CONV run shift-add-3 (double-dabble) conversion, one bit per clock, for exactly CNT_W clocks with busy=1, then enter SHOW.
REQ-022 SHALL retain only the DIGITS least-significant BCD digits; higher digits are silently dropped.
REQ-023 SHALL on entry to SHOW set page_idx=NPAGES-1, page_valid=1 and busy=0.
REQ-024 SHALL in SHOW hold each page for TICK_DIV clocks, then decrement page_idx, wrapping from 0 to NPAGES-1.
REQ-025 SHALL pad digit positions at or above DIGITS on the top page with 4'hF.
REQ-026 SHALL, on a toggle pulse in CONV or SHOW, abort, set running=1 and return to IDLE on the next clock; no partial result is displayed.
REQ-027 SHALL let clr asserted in CONV or SHOW clear only count; the snapshot and display are unaffected.
REQ-028 SHALL register all outputs with no combinational path from inputs.

Reset
REQ-029 SHALL on rst=1, independent of clock, set running=0, count=0, state=IDLE, busy=0, page_valid=0, page_idx=0, digits all 4'hF, synchroniser flops=1 and dwell counter=0.
REQ-030 SHALL, when rst deasserts, hold everything in IDLE until the first toggle pulse; rst asserted during CONV discards the conversion.

Verification (CNT_W=16, DIGITS=5, PAGE_DIGITS=3, TICK_DIV=4)
REQ-031 SHALL cover reset: assert rst mid-SHOW -> immediately digits=FFF, page_valid=0, running=0, busy=0.
REQ-032 SHALL cover count and convert: two toggle presses whose synchronised pulses are 1234 clocks apart -> busy high for 16 clocks, then page 1 = F,0,1 and page 0 = 2,3,4, each held 4 clocks and alternating.
REQ-033 SHALL cover wrap: run for 65541 clocks then stop -> display shows 00005.
REQ-034 SHALL cover abort: toggle 5 clocks into CONV -> running=1, IDLE, digits=FFF, page_valid never asserted.
REQ-035 SHALL cover clear priority: clr held during running for 10 clocks, then run 7 clocks and stop -> display shows 00007.
REQ-036 SHALL cover the synchroniser: a 1-clock low glitch aligned to clock -> at most one toggle; a held-low button -> exactly one toggle.

Source files
------------

// File: rtl/cycle_count_display.sv
// Pushbutton stopwatch counting clock cycles. Each stop converts the snapshot to BCD
// by double-dabble and pages the digits, most-significant page first, on a short display.
module cycle_count_display #(
    parameter int CNT_W       = 36,
    parameter int DIGITS      = 11,
    parameter int PAGE_DIGITS = 3,
    parameter int TICK_DIV    = 25000000,
    localparam int NPAGES     = (DIGITS + PAGE_DIGITS - 1) / PAGE_DIGITS,
    localparam int PG_W       = (NPAGES > 1) ? $clog2(NPAGES) : 1
) (
    input  logic                     CLOCK_50,
    input  logic                     rst,
    input  logic                     toggle_btn,
    input  logic                     clr,
    output logic [4*PAGE_DIGITS-1:0] digits,
    output logic [PG_W-1:0]          page_idx,
    output logic                     page_valid,
    output logic                     running,
    output logic                     busy
);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int PAGE_W = 4 * PAGE_DIGITS;
    localparam int PAD_W  = PAGE_W * NPAGES;
    localparam int BIT_W  = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CNT_W - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICK_DIV - 1);
    localparam logic [PG_W-1:0]   TOP_PAGE  = PG_W'(NPAGES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SHOW
    } state_t;

    logic              sync1_q;
    logic              sync2_q;
    logic              sync_prev_q;
    logic              toggle_pulse;

    state_t            state_q,   state_d;
    logic              running_q, running_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic [CNT_W-1:0]  bin_q,     bin_d;
    logic [BCD_W-1:0]  bcd_q,     bcd_d;
    logic [BIT_W-1:0]  bit_q,     bit_d;
    logic [TICK_W-1:0] tick_q,    tick_d;
    logic [PG_W-1:0]   page_q,    page_d;
    logic [PAGE_W-1:0] digits_q,  digits_d;
    logic              valid_q,   valid_d;
    logic              busy_q,    busy_d;

    logic [BCD_W-1:0]  bcd_adj;
    logic [PAD_W-1:0]  bcd_pad;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sync_prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value;
            // blocking here would collapse the synchroniser chain into one flop.
            sync1_q     <= toggle_btn;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
        end
    end

    assign toggle_pulse = sync_prev_q & ~sync2_q;

    always_comb begin
        // NOTE: every next-state value gets its hold default first, so no branch
        // can leave a signal unassigned and infer a latch.
        state_d   = state_q;
        running_d = running_q;
        count_d   = count_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        bit_d     = bit_q;
        tick_d    = tick_q;
        page_d    = page_q;
        digits_d  = '1;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        bcd_adj   = bcd_q;
        bcd_pad   = '1;

        if (clr) begin
            count_d = '0;
        end else if (running_q) begin
            count_d = count_q + CNT_W'(1);
        end

        if (toggle_pulse) begin
            running_d = ~running_q;
        end

        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        unique case (state_q)
            IDLE: begin
                // Snapshot includes this cycle's increment so the result equals count after the stop.
                if (toggle_pulse && running_q) begin
                    state_d = CONV;
                    bin_d   = count_d;
                    bcd_d   = '0;
                    bit_d   = '0;
                end
            end
            CONV: begin
                if (toggle_pulse) begin
                    state_d   = IDLE;
                    running_d = 1'b1;
                    page_d    = '0;
                    tick_d    = '0;
                end else begin
                    bcd_d = {bcd_adj[BCD_W-2:0], bin_q[CNT_W-1]};
                    bin_d = bin_q << 1;
                    bit_d = bit_q + BIT_W'(1);
                    if (bit_q == LAST_BIT) begin
                        state_d = SHOW;
                        page_d  = TOP_PAGE;
                        tick_d  = '0;
                    end
                end
            end
            SHOW: begin
                if (toggle_pulse) begin
                    state_d   = IDLE;
                    running_d = 1'b1;
                    page_d    = '0;
                    tick_d    = '0;
                end else if (tick_q == LAST_TICK) begin
                    tick_d = '0;
                    page_d = (page_q == '0) ? TOP_PAGE : page_q - PG_W'(1);
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                page_d  = '0;
                tick_d  = '0;
            end
        endcase

        // Positions above the converted digits read as blank on the top page.
        bcd_pad[BCD_W-1:0] = bcd_d;
        if (state_d == SHOW) begin
            for (int p = 0; p < NPAGES; p++) begin
                if (page_d == PG_W'(p)) begin
                    digits_d = bcd_pad[p*PAGE_W +: PAGE_W];
                end
            end
        end
        valid_d = (state_d == SHOW);
        busy_d  = (state_d == CONV);
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            count_q   <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            bit_q     <= '0;
            tick_q    <= '0;
            page_q    <= '0;
            digits_q  <= '1;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            count_q   <= count_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            bit_q     <= bit_d;
            tick_q    <= tick_d;
            page_q    <= page_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign digits     = digits_q;
    assign page_idx   = page_q;
    assign page_valid = valid_q;
    assign running    = running_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_cycle_count_display.sv
// Scoreboarded bench: the driver predicts each displayed value from press/clear timing,
// and an independent negedge monitor checks busy length, page order and digits.
module tb_cycle_count_display;
    localparam int CNT_W       = 16;
    localparam int DIGITS      = 5;
    localparam int PAGE_DIGITS = 3;
    localparam int TICK_DIV    = 4;
    localparam int NPAGES      = (DIGITS + PAGE_DIGITS - 1) / PAGE_DIGITS;
    localparam int SYNC_LAT    = 3;  // button drive edge to the edge where running flips
    localparam int MOD         = 1 << CNT_W;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     toggle_btn;
    logic                     clr;
    logic [4*PAGE_DIGITS-1:0] digits;
    logic [0:0]               page_idx;
    logic                     page_valid;
    logic                     running;
    logic                     busy;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int exp_q[$];
    int m_cnt = 0;
    int m_seg = 0;
    int stop_p = 0;
    int last_p = 0;
    bit m_running = 1'b0;
    bit pending = 1'b0;
    bit mon_en = 1'b0;

    cycle_count_display #(
        .CNT_W      (CNT_W),
        .DIGITS     (DIGITS),
        .PAGE_DIGITS(PAGE_DIGITS),
        .TICK_DIV   (TICK_DIV)
    ) dut (
        .CLOCK_50  (clk),
        .rst       (rst),
        .toggle_btn(toggle_btn),
        .clr       (clr),
        .digits    (digits),
        .page_idx  (page_idx),
        .page_valid(page_valid),
        .running   (running),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decimal page as the display should show it, padding positions beyond DIGITS with F.
    function automatic logic [4*PAGE_DIGITS-1:0] exp_page(input int val, input int pg);
        logic [4*PAGE_DIGITS-1:0] r;
        int v;
        int pos;
        r = '1;
        for (int k = 0; k < PAGE_DIGITS; k++) begin
            pos = pg * PAGE_DIGITS + k;
            v = val;
            for (int j = 0; j < pos; j++) v = v / 10;
            if (pos < DIGITS) r[4*k +: 4] = 4'(v % 10);
        end
        return r;
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int hold);
        int p;
        int tmp;
        @(posedge clk);
        #1;
        toggle_btn = 1'b0;
        p = cyc;
        last_p = p;
        if (m_running) begin
            m_cnt = (m_cnt + (p + SYNC_LAT - m_seg)) % MOD;
            m_running = 1'b0;
            exp_q.push_back(m_cnt);
            stop_p = p;
            pending = 1'b1;
        end else begin
            // A press that lands while still converting cancels the pending display.
            if (pending && (p <= stop_p + CNT_W)) tmp = exp_q.pop_back();
            pending = 1'b0;
            m_running = 1'b1;
            m_seg = p + SYNC_LAT;
        end
        repeat (hold) @(posedge clk);
        #1 toggle_btn = 1'b1;
        wait_until(p + SYNC_LAT + 1);
        check("running_after_press", running, m_running);
    endtask

    task automatic press_at(input int t, input int hold);
        wait_until(t - 1);
        press(hold);
    endtask

    task automatic clear(input int n);
        @(posedge clk);
        #1 clr = 1'b1;
        repeat (n) @(posedge clk);
        #1 clr = 1'b0;
        m_cnt = 0;
        if (m_running) m_seg = cyc;
    endtask

    task automatic show_abort(input int extra);
        press_at(stop_p + SYNC_LAT + CNT_W + extra, 2);
    endtask

    // Monitor: pops the expected value when a display starts and checks every shown cycle.
    int  busy_run = 0;
    int  last_busy = 0;
    bit  busy_prev = 1'b0;
    bit  valid_prev = 1'b0;
    bit  have_cur = 1'b0;
    int  cur_val = 0;
    int  show_cyc = 0;
    int  exp_idx;

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) begin
                busy_run++;
            end else begin
                if (busy_prev) last_busy = busy_run;
                busy_run = 0;
            end
            busy_prev = busy;
            if (page_valid && !valid_prev) begin
                check("busy_len", last_busy, CNT_W);
                check("expected_display_queued", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur_val = exp_q.pop_front();
                    have_cur = 1'b1;
                end
                show_cyc = 0;
            end
            if (page_valid) begin
                check("busy_in_show", busy, 0);
                if (have_cur) begin
                    exp_idx = NPAGES - 1 - ((show_cyc / TICK_DIV) % NPAGES);
                    check("page_idx", page_idx, exp_idx);
                    check("digits", digits, exp_page(cur_val, exp_idx));
                end
                show_cyc++;
            end else begin
                have_cur = 1'b0;
                check("idle_digits", digits, 12'hFFF);
                check("idle_page_idx", page_idx, 0);
            end
            valid_prev = page_valid;
        end
    end

    initial begin
        int start_p;
        int c;
        rst = 1'b1;
        toggle_btn = 1'b1;
        clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_digits", digits, 12'hFFF);
        check("reset_valid", page_valid, 0);
        check("reset_running", running, 0);
        check("reset_busy", busy, 0);
        check("reset_page_idx", page_idx, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_until_toggle", running, 0);

        // One-clock glitch starts the counter once; a long hold stops it once.
        press(1);
        start_p = last_p;
        repeat (10) @(posedge clk);
        #1;
        check("glitch_single_toggle", running, 1);
        press_at(start_p + 40, 20);
        repeat (5) @(posedge clk);
        #1;
        check("held_single_toggle", running, 0);
        show_abort(12);

        // Clear during SHOW leaves the display alone.
        press_at(last_p + 10, 1);
        wait_until(stop_p + SYNC_LAT + CNT_W + 6);
        clear(3);
        show_abort(20);

        // Count from zero for 1234 clocks.
        start_p = last_p;
        press_at(start_p + 1234, 2);
        show_abort(20);

        // Clear held 10 clocks while running, then 7 more clocks.
        repeat (10) @(posedge clk);
        clear(10);
        c = cyc;
        press_at(c + 4, 1);
        show_abort(12);

        // Wrap past 2^16.
        clear(1);
        c = cyc;
        press_at(c + 65541 - SYNC_LAT, 1);
        show_abort(12);

        // Abort five clocks into the conversion.
        press_at(last_p + 30, 1);
        press_at(stop_p + 5, 1);
        repeat (4) @(posedge clk);
        #1;
        check("abort_running", running, 1);
        check("abort_busy", busy, 0);
        check("abort_valid", page_valid, 0);
        check("abort_digits", digits, 12'hFFF);
        repeat (40) @(posedge clk);

        for (int it = 0; it < 8; it++) begin
            int gap;
            int d;
            start_p = last_p;
            gap = $urandom_range(20, 1500);
            if ($urandom_range(0, 2) == 0) begin
                wait_until(start_p + SYNC_LAT + 2 + gap / 2);
                clear($urandom_range(1, 5));
            end
            press_at((cyc + 2 > start_p + gap) ? cyc + 2 : start_p + gap, $urandom_range(1, 3));
            d = $urandom_range(0, 30);
            press_at(stop_p + 5 + d, $urandom_range(1, 3));
        end
        repeat (30) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        // Reset in the middle of a display.
        press_at(last_p + 50, 1);
        wait_until(stop_p + SYNC_LAT + CNT_W + 5);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midshow_rst_digits", digits, 12'hFFF);
        check("midshow_rst_valid", page_valid, 0);
        check("midshow_rst_running", running, 0);
        check("midshow_rst_busy", busy, 0);
        exp_q.delete();
        m_cnt = 0;
        m_running = 1'b0;
        pending = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_running", running, 0);
        check("post_rst_valid", page_valid, 0);

        press(2);
        start_p = last_p;
        press_at(start_p + 40, 1);
        show_abort(10);
        repeat (20) @(posedge clk);
        #1;
        check("final_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
